mac_row_os_ctrl: RTL

- Parametrised MAC row for the reconfigurable array.
- Supports two modes:
  - Weight-stationary (WS): each column holds a weight, and partial sums flow north to south.
  - Output-stationary (OS): each column accumulates locally over a programmable number of MACs.
- In OS mode an internal drain sequencer serialises completed column results onto a single valid/ready output port, so the OFIFO is fed one word at a time.
- Adds overrun detection and a mode-change flush.

---
 rtl/mac_row_os_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mac_row_os_ctrl.sv
// MAC row with weight-stationary and output-stationary modes. In OS mode a drain
// sequencer hands completed column results to a single valid/ready port.

module mac_row_os_col #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int cnt_bw  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mode_q,
   input  logic               flush,
   input  logic [bw-1:0]      a_in,
   input  logic [1:0]         inst_in,
   input  logic [psum_bw-1:0] n_in,
   input  logic [cnt_bw-1:0]  accum_limit,
   input  logic               clr,
   output logic [psum_bw-1:0] s_out,
   output logic               vld,
   output logic [psum_bw-1:0] hold,
   output logic               pend,
   output logic               drop
);
   logic        [bw-1:0]      weight;
   logic        [psum_bw-1:0] acc;
   logic        [cnt_bw-1:0]  cnt;
   logic        [cnt_bw-1:0]  cnt_nx;
   logic signed [bw-1:0]      w_use;
   logic signed [2*bw:0]      prod_s;
   logic        [psum_bw-1:0] prod;
   logic        [psum_bw-1:0] sum;
   logic                      exec;
   logic                      done;

   assign exec   = inst_in[0];
   assign w_use  = mode_q ? n_in[bw-1:0] : weight;
   assign prod_s = $signed({1'b0, a_in}) * w_use;
   assign prod   = psum_bw'(prod_s);
   assign sum    = acc + prod;
   assign cnt_nx = cnt + 1'b1;
   // A zero limit never completes, even when the counter wraps back to zero.
   assign done   = mode_q & exec & (accum_limit != '0) & (cnt_nx == accum_limit);
   assign drop   = done & pend & ~clr & ~flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         weight <= '0;
         acc    <= '0;
         cnt    <= '0;
         s_out  <= '0;
         vld    <= 1'b0;
         hold   <= '0;
         pend   <= 1'b0;
      end else if (flush) begin
         acc  <= '0;
         cnt  <= '0;
         pend <= 1'b0;
         vld  <= 1'b0;
      end else begin
         if (clr) pend <= 1'b0;
         vld <= exec;
         if (mode_q) begin
            s_out <= psum_bw'($signed(n_in[bw-1:0]));
            if (exec) begin
               if (done) begin
                  acc  <= '0;
                  cnt  <= '0;
                  pend <= 1'b1;
                  if (!pend || clr) hold <= sum;
               end else begin
                  acc <= sum;
                  cnt <= cnt_nx;
               end
            end
         end else begin
            if (exec) s_out <= n_in + prod;
            if (inst_in[1]) weight <= a_in;
         end
      end
   end
endmodule

module mac_row_os_ctrl #(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int cnt_bw  = 8,
   parameter int idx_bw  = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mode,
   input  logic [bw-1:0]          in_w,
   input  logic [1:0]             inst_w,
   input  logic [psum_bw*col-1:0] in_n,
   input  logic [cnt_bw-1:0]      accum_limit,
   output logic [psum_bw*col-1:0] out_s,
   output logic [col-1:0]         valid,
   output logic [psum_bw-1:0]     os_out_data,
   output logic [idx_bw-1:0]      os_out_col,
   output logic                   os_out_valid,
   input  logic                   os_out_ready,
   output logic [col-1:0]         os_pending,
   output logic                   overrun
);
   typedef enum logic {IDLE, PRESENT} drain_st_t;

   drain_st_t                       st_q, st_d;
   logic                            mode_q;
   logic                            flush;
   logic [col-1:1][bw-1:0]          a_pipe;
   logic [col-1:1][1:0]             inst_pipe;
   logic [col-1:0][psum_bw-1:0]     hold_v;
   logic [col-1:0]                  drop_v;
   logic [col-1:0]                  clr_vec;
   logic [col-1:0]                  rem;
   logic [col-1:0]                  src;
   logic [idx_bw-1:0]               pick;
   logic [psum_bw-1:0]              data_d;
   logic [idx_bw-1:0]               col_d;
   logic                            ovld_d;

   assign flush   = mode ^ mode_q;
   assign clr_vec = (os_out_valid && os_out_ready) ?
                    ({{(col-1){1'b0}}, 1'b1} << os_out_col) : '0;
   assign rem     = os_pending & ~clr_vec;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q    <= 1'b0;
         a_pipe    <= '0;
         inst_pipe <= '0;
         overrun   <= 1'b0;
      end else begin
         mode_q       <= mode;
         a_pipe[1]    <= in_w;
         inst_pipe[1] <= inst_w;
         for (int c = 2; c < col; c++) begin
            a_pipe[c]    <= a_pipe[c-1];
            inst_pipe[c] <= inst_pipe[c-1];
         end
         overrun <= overrun | (|drop_v);
      end
   end

   for (genvar c = 0; c < col; c++) begin : g_col
      logic [bw-1:0] a_c;
      logic [1:0]    i_c;
      if (c == 0) begin : g_west
         assign a_c = in_w;
         assign i_c = inst_w;
      end else begin : g_fwd
         assign a_c = a_pipe[c];
         assign i_c = inst_pipe[c];
      end
      mac_row_os_col #(.bw(bw), .psum_bw(psum_bw), .cnt_bw(cnt_bw)) u_col (
         .clk         (clk),
         .reset       (reset),
         .mode_q      (mode_q),
         .flush       (flush),
         .a_in        (a_c),
         .inst_in     (i_c),
         .n_in        (in_n[c*psum_bw +: psum_bw]),
         .accum_limit (accum_limit),
         .clr         (clr_vec[c]),
         .s_out       (out_s[c*psum_bw +: psum_bw]),
         .vld         (valid[c]),
         .hold        (hold_v[c]),
         .pend        (os_pending[c]),
         .drop        (drop_v[c])
      );
   end

   // From IDLE pick among all pending; while presenting, skip the word leaving now.
   always_comb begin
      src  = (st_q == IDLE) ? os_pending : rem;
      pick = '0;
      for (int i = col-1; i >= 0; i--)
         if (src[i]) pick = idx_bw'(i);
   end

   always_comb begin
      st_d   = st_q;
      data_d = os_out_data;
      col_d  = os_out_col;
      ovld_d = os_out_valid;
      if (flush) begin
         st_d   = IDLE;
         ovld_d = 1'b0;
      end else begin
         case (st_q)
            IDLE: begin
               if (|os_pending) begin
                  st_d   = PRESENT;
                  col_d  = pick;
                  data_d = hold_v[pick];
                  ovld_d = 1'b1;
               end
            end
            PRESENT: begin
               if (os_out_valid && os_out_ready) begin
                  if (|rem) begin
                     col_d  = pick;
                     data_d = hold_v[pick];
                  end else begin
                     st_d   = IDLE;
                     ovld_d = 1'b0;
                  end
               end
            end
            default: st_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q         <= IDLE;
         os_out_data  <= '0;
         os_out_col   <= '0;
         os_out_valid <= 1'b0;
      end else begin
         st_q         <= st_d;
         os_out_data  <= data_d;
         os_out_col   <= col_d;
         os_out_valid <= ovld_d;
      end
   end
endmodule
